// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared definitions for the multi-channel HC-SR04 controller.
//   estado_t      - FSM state encoding; the value doubles as the db_estado code
//   DB_ILEGAL     - debug code shown while the state register holds a bad value
//   ERR_*         - erro_cod values delivered with each measurement
//   clog2w / maxi - elaboration-time width helpers
package hcsr04_pkg;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARACAO    = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDIDA        = 4'd4,
        ARMAZENA      = 4'd5,
        PAUSA         = 4'd6,
        FINAL         = 4'd15
    } estado_t;

    localparam logic [3:0] DB_ILEGAL   = 4'd14;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LONGO   = 2'b10;

    // Bits needed to index/count v distinct values, never less than 1.
    function automatic int clog2w(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int maxi(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/contador_param.sv
// contador_param: modulo-MAX up counter with synchronous clear.
//   clock, reset - system clock, synchronous active-high reset
//   zera         - clear to 0 (wins over conta)
//   conta        - count enable; wraps to 0 after MAX-1
//   Q            - current count
//   fim          - high while Q == MAX-1
module contador_param #(
    parameter int WIDTH = 8,
    parameter int MAX   = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    output logic [WIDTH-1:0] Q,
    output logic             fim
);

    localparam logic [WIDTH-1:0] ULT = WIDTH'(MAX - 1);

    assign fim = (Q == ULT);

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            Q <= '0;
        end else if (conta) begin
            Q <= fim ? '0 : Q + WIDTH'(1);
        end
    end

endmodule

// File: rtl/hcsr04_multi_ctrl.sv
// hcsr04_multi_ctrl: round-robin controller for N_CH HC-SR04 ultrasonic sensors.
// Per channel: trigger pulse, wait for echo (timeout + bounded retries),
// measure echo width, strobe the result, then an idle gap before the next channel.
//   clock, reset   - system clock, synchronous active-high reset
//   medir          - start a sweep (only looked at in INICIAL)
//   continuo       - restart the sweep after FINAL (only looked at in FINAL)
//   echo           - raw asynchronous echo inputs, one per sensor
//   trigger        - trigger outputs, at most one bit high
//   canal          - channel being worked on / of the strobed result
//   medida         - echo width in clocks, held until the next strobe
//   erro_cod       - 00 ok, 01 no echo, 10 echo too long; held with medida
//   medida_valida  - 1-cycle result strobe
//   pronto         - 1-cycle end-of-sweep strobe
//   ocupado        - high outside INICIAL
//   db_estado      - debug state code
module hcsr04_multi_ctrl
    import hcsr04_pkg::*;
#(
    parameter int N_CH            = 2,
    parameter int TRIG_CYCLES     = 500,
    parameter int TIMEOUT_CYCLES  = 1_000_000,
    parameter int MAX_ECHO_CYCLES = 1_200_000,
    parameter int MAX_RETRY       = 2,
    parameter int GAP_CYCLES      = 3_000_000,
    parameter int ECHO_W          = 21,
    parameter int CH_W            = clog2w(N_CH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              medir,
    input  logic              continuo,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trigger,
    output logic [CH_W-1:0]   canal,
    output logic [ECHO_W-1:0] medida,
    output logic [1:0]        erro_cod,
    output logic              medida_valida,
    output logic              pronto,
    output logic              ocupado,
    output logic [3:0]        db_estado
);

    // One timer serves trigger, timeout and gap; it is sized for the longest.
    localparam int TMR_MAX = maxi(maxi(TRIG_CYCLES, TIMEOUT_CYCLES), GAP_CYCLES);
    localparam int TMR_W   = clog2w(TMR_MAX);
    localparam int RET_W   = clog2w(MAX_RETRY + 1);

    localparam logic [TMR_W-1:0] TRIG_ULT    = TMR_W'(TRIG_CYCLES - 1);
    localparam logic [TMR_W-1:0] TIMEOUT_ULT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_ULT     = TMR_W'(GAP_CYCLES - 1);
    localparam logic [CH_W-1:0]  CANAL_ULT   = CH_W'(N_CH - 1);
    localparam logic [RET_W-1:0] RETRY_MAX   = RET_W'(MAX_RETRY);

    estado_t            estado;
    logic [RET_W-1:0]   retry;

    // Two-flop synchroniser, all channels in parallel.
    logic [1:0][N_CH-1:0] echo_pipe;
    logic [N_CH-1:0]      echo_s;
    logic                 eco;

    always_ff @(posedge clock) begin
        if (reset) echo_pipe <= '0;
        else       echo_pipe <= {echo_pipe[0], echo};
    end

    assign echo_s = echo_pipe[1];
    assign eco    = echo_s[canal];

    // Shared timer: counts only in the timed states and is cleared on every
    // exit, so each timed state starts from 0.
    logic [TMR_W-1:0] tmr_q;
    logic             tmr_fim, tmr_conta, tmr_ult_hit, tmr_end, tmr_zera;

    always_comb begin
        tmr_conta   = 1'b0;
        tmr_ult_hit = 1'b0;
        case (estado)
            ENVIA_TRIGGER: begin tmr_conta = 1'b1; tmr_ult_hit = (tmr_q == TRIG_ULT);    end
            ESPERA_ECHO:   begin tmr_conta = 1'b1; tmr_ult_hit = (tmr_q == TIMEOUT_ULT); end
            PAUSA:         begin tmr_conta = 1'b1; tmr_ult_hit = (tmr_q == GAP_ULT);     end
            default: ;
        endcase
    end

    assign tmr_end  = tmr_conta && (tmr_ult_hit || tmr_fim);
    assign tmr_zera = !tmr_conta || tmr_end;

    contador_param #(.WIDTH(TMR_W), .MAX(TMR_MAX)) u_tmr (
        .clock (clock),
        .reset (reset),
        .zera  (tmr_zera),
        .conta (tmr_conta),
        .Q     (tmr_q),
        .fim   (tmr_fim)
    );

    // Echo width: the rising cycle in ESPERA_ECHO already counts, so the value
    // on the first MEDIDA cycle is 1 and equals the high-cycle count on fall.
    logic [ECHO_W-1:0] larg_q;
    logic              larg_fim, larg_conta, larg_zera;

    assign larg_conta = eco && (estado == ESPERA_ECHO || estado == MEDIDA);
    assign larg_zera  = !(estado == MEDIDA || larg_conta);

    contador_param #(.WIDTH(ECHO_W), .MAX(MAX_ECHO_CYCLES + 1)) u_larg (
        .clock (clock),
        .reset (reset),
        .zera  (larg_zera),
        .conta (larg_conta),
        .Q     (larg_q),
        .fim   (larg_fim)
    );

    logic [N_CH-1:0] trig_sel;

    always_comb begin
        trig_sel        = '0;
        trig_sel[canal] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= INICIAL;
            canal         <= '0;
            retry         <= '0;
            trigger       <= '0;
            medida        <= '0;
            erro_cod      <= ERR_OK;
            medida_valida <= 1'b0;
            pronto        <= 1'b0;
        end else begin
            medida_valida <= 1'b0;
            pronto        <= 1'b0;
            case (estado)
                INICIAL: begin
                    if (medir) begin
                        estado <= PREPARACAO;
                        canal  <= '0;
                        retry  <= '0;
                    end
                end
                PREPARACAO: begin
                    estado  <= ENVIA_TRIGGER;
                    trigger <= trig_sel;
                end
                ENVIA_TRIGGER: begin
                    if (tmr_end) begin
                        estado  <= ESPERA_ECHO;
                        trigger <= '0;
                    end
                end
                ESPERA_ECHO: begin
                    // Echo is checked first so it wins over a same-cycle timeout.
                    if (eco) begin
                        estado <= MEDIDA;
                    end else if (tmr_end) begin
                        if (retry < RETRY_MAX) begin
                            retry   <= retry + RET_W'(1);
                            estado  <= ENVIA_TRIGGER;
                            trigger <= trig_sel;
                        end else begin
                            estado        <= ARMAZENA;
                            medida        <= '0;
                            erro_cod      <= ERR_TIMEOUT;
                            medida_valida <= 1'b1;
                        end
                    end
                end
                MEDIDA: begin
                    if (!eco) begin
                        estado        <= ARMAZENA;
                        medida        <= larg_q;
                        erro_cod      <= ERR_OK;
                        medida_valida <= 1'b1;
                    end else if (larg_fim) begin
                        estado        <= ARMAZENA;
                        medida        <= ECHO_W'(MAX_ECHO_CYCLES);
                        erro_cod      <= ERR_LONGO;
                        medida_valida <= 1'b1;
                    end
                end
                // Result registers were loaded on entry; the strobe is live now.
                ARMAZENA: estado <= PAUSA;
                PAUSA: begin
                    if (tmr_end) begin
                        if (canal != CANAL_ULT) begin
                            canal  <= canal + CH_W'(1);
                            retry  <= '0;
                            estado <= PREPARACAO;
                        end else begin
                            estado <= FINAL;
                            pronto <= 1'b1;
                        end
                    end
                end
                FINAL: begin
                    if (continuo) begin
                        estado <= PREPARACAO;
                        canal  <= '0;
                        retry  <= '0;
                    end else begin
                        estado <= INICIAL;
                    end
                end
                default: begin
                    estado  <= INICIAL;
                    trigger <= '0;
                end
            endcase
        end
    end

    assign ocupado = (estado != INICIAL);

    always_comb begin
        case (estado)
            INICIAL, PREPARACAO, ENVIA_TRIGGER, ESPERA_ECHO,
            MEDIDA, ARMAZENA, PAUSA, FINAL: db_estado = estado;
            default:                        db_estado = DB_ILEGAL;
        endcase
    end

endmodule
